// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the scoreboarded register file
// Contents: default DATA_W/ADDR_W values and the clear-sequencer state encoding.
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_file_clr_seq.sv
// rtl/reg_file_clr_seq.sv - one-entry-per-cycle clear sweep sequencer
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   clr_req                 start a sweep (ignored while a sweep is running)
//   clr_busy                high for exactly 2**ADDR_W cycles per sweep
//   sweep_we, sweep_addr    clear strobe and the entry it targets this cycle
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  clr_state_t        state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLR_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          ptr <= '0;
          if (clr_req) state <= CLR_SWEEP;
        end
        CLR_SWEEP: begin
          // ptr wraps to zero naturally after the all-ones entry.
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= CLR_IDLE;
        end
        default: begin
          state <= CLR_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign clr_busy   = (state == CLR_SWEEP);
  assign sweep_we   = (state == CLR_SWEEP);
  assign sweep_addr = ptr;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 1W/2R register file with write-through bypass, pending scoreboard and clear sweep
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data     write port (dropped while clr_busy)
//   rsv_en/rsv_addr           mark an entry pending (dropped while clr_busy)
//   aa/a/a_pend, ba/b/b_pend  combinational read ports with pending bits
//   clr_req, clr_busy, wr_ok  clear sweep control; wr_ok = ~clr_busy
// Build option: define ZERO_REG_EN to hardwire entry 0 to zero.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] aa,
  input  logic [ADDR_W-1:0] ba,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              a_pend,
  output logic              b_pend,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_ok
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_fire;
  logic              rsv_fire;

  reg_file_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign wr_ok = ~clr_busy;

`ifdef ZERO_REG_EN
  assign wr_fire  = wr_en  & ~clr_busy & (wr_addr  != '0);
  assign rsv_fire = rsv_en & ~clr_busy & (rsv_addr != '0);
`else
  assign wr_fire  = wr_en  & ~clr_busy;
  assign rsv_fire = rsv_en & ~clr_busy;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else if (sweep_we) begin
      mem[sweep_addr]  <= '0;
      pend[sweep_addr] <= 1'b0;
    end else begin
      if (wr_fire) begin
        mem[wr_addr]  <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      // Reserve after write: a freshly issued producer keeps the entry pending.
      if (rsv_fire) pend[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    a = mem[aa];
    if (wr_fire && (wr_addr == aa)) a = wr_data;
`ifdef ZERO_REG_EN
    if (aa == '0) a = '0;
`endif
  end

  always_comb begin
    b = mem[ba];
    if (wr_fire && (wr_addr == ba)) b = wr_data;
`ifdef ZERO_REG_EN
    if (ba == '0) b = '0;
`endif
  end

  assign a_pend = pend[aa];
  assign b_pend = pend[ba];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb
module tb_reg_file_sb;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic [AW-1:0] aa = '0;
  logic [AW-1:0] ba = '0;
  logic [DW-1:0] a, b;
  logic          a_pend, b_pend;
  logic          clr_req = 1'b0;
  logic          clr_busy, wr_ok;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Behavioural model: plain arrays plus a count of sweep cycles still to run.
  int m_mem [DEPTH];
  bit m_pend [DEPTH];
  int sweep_left = 0;

  reg_file_sb dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .aa(aa), .ba(ba), .a(a), .b(b), .a_pend(a_pend), .b_pend(b_pend),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_ok(wr_ok)
  );

  always #5 clk = ~clk;

  function automatic bit is_zero_reg(input int addr);
`ifdef ZERO_REG_EN
    return addr == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_pend[i] = 0; end
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      m_mem[DEPTH - sweep_left]  = 0;
      m_pend[DEPTH - sweep_left] = 0;
      sweep_left--;
    end else begin
      if (wr_en && !is_zero_reg(int'(wr_addr))) begin
        m_mem[wr_addr]  = int'(wr_data);
        m_pend[wr_addr] = 0;
      end
      if (rsv_en && !is_zero_reg(int'(rsv_addr))) m_pend[rsv_addr] = 1;
      if (clr_req) sweep_left = DEPTH;
    end
  end

  function automatic int exp_rd(input int addr);
    if (is_zero_reg(addr)) return 0;
    if (wr_en && sweep_left == 0 && !is_zero_reg(int'(wr_addr)) && int'(wr_addr) == addr)
      return int'(wr_data);
    return m_mem[addr];
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_a", int'(a), exp_rd(int'(aa)));
      chk("cyc_b", int'(b), exp_rd(int'(ba)));
      chk("cyc_a_pend", int'(a_pend), int'(m_pend[aa]));
      chk("cyc_b_pend", int'(b_pend), int'(m_pend[ba]));
      chk("cyc_clr_busy", int'(clr_busy), int'(sweep_left > 0));
      chk("cyc_wr_ok", int'(wr_ok), int'(sweep_left == 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; clr_req = 0;
  endtask

  task automatic wr(input int addr, input int data);
    idle();
    wr_en = 1; wr_addr = AW'(addr); wr_data = DW'(data);
    step();
  endtask

  int busy_cnt;

  initial begin
    reset_n = 0;
    step(); step();
    reset_n = 1;
    check_en = 1;
    #1;
    chk("rst_a", int'(a), 0);
    chk("rst_pend", int'(a_pend), 0);
    chk("rst_wr_ok", int'(wr_ok), 1);
    chk("rst_busy", int'(clr_busy), 0);

    wr(3, 'h5A);
    wr(5, 'hC3);
    idle(); aa = 3; ba = 5; #1;
    chk("rd_a_r3", int'(a), 'h5A);
    chk("rd_b_r5", int'(b), 'hC3);
    chk("rd_pend_r3", int'(a_pend), 0);
    chk("rd_pend_r5", int'(b_pend), 0);

    step();
    wr_en = 1; wr_addr = 2; wr_data = 'h77; aa = 2; #1;
    chk("bypass_a", int'(a), 'h77);
    step();

    idle(); rsv_en = 1; rsv_addr = 4; step();
    idle(); aa = 4; #1;
    chk("rsv_pend_r4", int'(a_pend), 1);
    wr(4, 'h11);
    idle(); #1;
    chk("wr_clr_pend_r4", int'(a_pend), 0);
    chk("wr_data_r4", int'(a), 'h11);

    idle(); wr_en = 1; wr_addr = 6; wr_data = 'h3C; rsv_en = 1; rsv_addr = 6; step();
    idle(); aa = 6; #1;
    chk("wr_rsv_r6_data", int'(a), 'h3C);
    chk("wr_rsv_r6_pend", int'(a_pend), 1);

    for (int i = 0; i < DEPTH; i++) wr(i, 'hFF);
    idle(); clr_req = 1; step();
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i == 1) begin wr_en = 1; wr_addr = 1; wr_data = 'hAA; aa = 1; end
      if (i == 3) clr_req = 1;
      #1;
      if (i == 1) chk("sweep_wr_ok", int'(wr_ok), 0);
      if (clr_busy) busy_cnt++;
      step();
    end
    chk("sweep_busy_cycles", busy_cnt, DEPTH);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      aa = AW'(i); #1;
      chk("post_sweep_zero", int'(a), 0);
    end
    step();

    for (int i = 0; i < DEPTH; i++) wr(i, 'h10 + i);
    idle(); clr_req = 1; step();
    idle(); step(); step();
    reset_n = 0; step();
    reset_n = 1; #1;
    chk("rst_mid_busy", int'(clr_busy), 0);
    chk("rst_mid_wr_ok", int'(wr_ok), 1);
    for (int i = 0; i < DEPTH; i++) begin
      aa = AW'(i); ba = AW'(DEPTH - 1 - i); #1;
      chk("rst_mid_a_zero", int'(a), 0);
      chk("rst_mid_b_zero", int'(b), 0);
    end
    step();

    idle(); wr_en = 1; wr_addr = 0; wr_data = 'h99; aa = 0; #1;
`ifdef ZERO_REG_EN
    chk("zr_bypass", int'(a), 0);
`else
    chk("r0_bypass", int'(a), 'h99);
`endif
    step();
    idle(); #1;
`ifdef ZERO_REG_EN
    chk("zr_after", int'(a), 0);
`else
    chk("r0_after", int'(a), 'h99);
`endif
    rsv_en = 1; rsv_addr = 0; step();
    idle(); #1;
`ifdef ZERO_REG_EN
    chk("zr_pend", int'(a_pend), 0);
`else
    chk("r0_pend", int'(a_pend), 1);
`endif
    step(); step();

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-word register file, successor to the fixed 8x8 two-read-port file in the datapath.
- One write port and two combinational read ports (A, B), with write-through bypass.
- Per-register pending scoreboard, so the control unit can detect RAW hazards.
- Multi-cycle clear sequencer that zeroes the file one entry per cycle without asserting reset.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve strobe; marks an entry pending (producer issued)
rsv_addr  in  ADDR_W  reserve address
aa  in  ADDR_W  read port A address
ba  in  ADDR_W  read port B address
a  out  DATA_W  port A data (combinational)
b  out  DATA_W  port B data (combinational)
a_pend  out  1  pending bit of entry aa
b_pend  out  1  pending bit of entry ba
clr_req  in  1  start clear sweep (pulse)
clr_busy  out  1  sweep in progress
wr_ok  out  1  write accepted this cycle; equals ~clr_busy

Behaviour:
- Reset (reset_n=0 at rising edge):
  - all DEPTH entries zero, all pending bits zero, FSM to IDLE, sweep pointer zero, clr_busy=0.
  - Reset overrides every other input that cycle, including mid-sweep.
  - Resulting outputs: a=b=0, a_pend=b_pend=0, wr_ok=1.
- Write:
  - If wr_en and not clr_busy, entry[wr_addr] <= wr_data at the edge.
  - The same edge clears pend[wr_addr].
  - If wr_en is asserted while clr_busy, the write is dropped and has no effect.
- Read: a = entry[aa], b = entry[ba], zero latency.
- Bypass:
  - If wr_en and not clr_busy and wr_addr==aa, then a=wr_data in the same cycle; likewise for b.
  - No bypass while clr_busy.
- Scoreboard:
  - rsv_en sets pend[rsv_addr] at the edge; it is ignored while clr_busy.
  - Write and reserve to the same address in the same cycle: data is written and pend ends at 1 (reserve wins, since a new producer has issued).
  - a_pend/b_pend reflect the registered pend bits; no bypass of the pending clear.
- Clear FSM has two states, IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req; ptr <= 0; clr_busy=1 from the next cycle.
  - In SWEEP, each cycle does entry[ptr] <= 0 and pend[ptr] <= 0, then ptr <= ptr+1.
  - When ptr == DEPTH-1, that entry is cleared, the FSM returns to IDLE and ptr wraps to 0.
  - The sweep takes exactly DEPTH cycles; clr_busy is high for DEPTH cycles.
  - clr_req while in SWEEP is ignored (no restart).
  - Reads during SWEEP return current contents: entries already swept read 0, entries not yet swept read their old values.
- Arithmetic: ptr is ADDR_W bits wide; terminal compare is against the all-ones address.

Optional Feature:
ZERO_REG_EN
- Defined:
  - entry 0 is hardwired to zero; writes and reserves to address 0 are dropped.
  - pend[0] is always 0.
  - Reads of address 0 return 0 even when a bypass write targets address 0.
  - The sweep still runs for DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Package reg_file_pkg:
  - default DATA_W/ADDR_W constants
  - enum clr_state_t {CLR_IDLE, CLR_SWEEP}
- Sub-module reg_file_clr_seq: FSM plus pointer, outputs clr_busy, sweep_we, sweep_addr.
- The top level holds the storage array, pending vector, read muxes and bypass.

Test Plan:
- Reset then write 0x5A to r3, write 0xC3 to r5; aa=3, ba=5 -> a=0x5A, b=0xC3 one cycle later; both pend=0.
- Bypass: wr_en=1, wr_addr=2, wr_data=0x77, aa=2 in the same cycle -> a=0x77 combinationally, before the edge.
- Scoreboard:
  - rsv_en for r4 -> a_pend=1 with aa=4.
  - Later, write 0x11 to r4 -> a_pend=0, a=0x11.
  - Simultaneous write and reserve on r6 -> data written, pend[6]=1.
- Sweep:
  - Fill r0..r7 with 0xFF, pulse clr_req -> clr_busy=1 for exactly 8 cycles.
  - A write of 0xAA to r1 during the sweep is dropped and wr_ok=0.
  - After the sweep, all entries read 0.
  - A second clr_req mid-sweep does not extend clr_busy.
- Reset mid-sweep: reset_n=0 at sweep cycle 3 -> next cycle clr_busy=0, all entries 0, FSM IDLE.
- ZERO_REG_EN: write 0x99 to r0 with aa=0 -> a=0 both before and after the edge; rsv_en to r0 leaves a_pend=0.
